bit_manip_unit: RTL
===================

BIT_MANIP_UNIT -- requirements
Module: bit_manip_unit

Interface
REQ-001 Parameter N, default 8, data width in bits; SHALL be >= 2.
REQ-002 Parameter LW, default $clog2(N)+1, width of the len port; SHALL be able to hold the value N.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request strobe; sampled only in IDLE.
REQ-006 a  input  N  operand word.
REQ-007 b  input  N  signed start bit index.
REQ-008 len  input  LW  unsigned number of consecutive bits to modify.
REQ-009 mode  input  2  00 toggle, 01 set, 10 clear, 11 reserved.
REQ-010 busy  output  1  high while state is RUN.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 result  output  N  registered result word.
REQ-013 error  output  1  registered error flag, valid with done.

Function
REQ-014 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 In IDLE with start=1, a, b, len and mode SHALL be captured at the clock edge.
REQ-016 The request is in error if any holds: b<0 (signed), b>=N, b+len>N (no overflow, extended width), or mode=11.
REQ-017 On an error request, next state SHALL be DONE, error SHALL be 1 and result SHALL be the captured a.
REQ-018 On a valid request with len=0, next state SHALL be DONE, error 0, result = a.
REQ-019 On a valid request with len>0, next state SHALL be RUN; working index = b, remaining = len.
REQ-020 Each RUN cycle SHALL modify exactly one bit (working index) per mode, then increment the index and decrement remaining.
REQ-021 When the last bit is modified, next state SHALL be DONE; result SHALL load the working word and error SHALL be 0 on that same edge.
REQ-022 Latency: start sampled in cycle 0 -> done high in cycle len+1 (valid, len>0) or cycle 1 (error or len=0).
REQ-023 done SHALL be high only in DONE, for exactly one cycle; next state is always IDLE.
REQ-024 result and error SHALL change only on entry to DONE or on reset, and SHALL hold between requests.
REQ-025 start SHALL be ignored in RUN and DONE; a start in the IDLE cycle directly after DONE SHALL be accepted.
REQ-026 Bits outside [b, b+len-1] SHALL equal the corresponding bits of a.
REQ-027 Inputs other than start MAY change during RUN without effect.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, busy 0, done 0, result 0, error 0, and clear working registers.
REQ-029 Reset during RUN SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-030 The first start SHALL be accepted on the first rising edge with rst_n=1.

Structure
REQ-031 Package bit_manip_pkg SHALL hold the mode enum (MODE_TOGGLE, MODE_SET, MODE_CLEAR, MODE_RSVD) and the state enum.
REQ-032 A combinational sub-module bit_op_cell (word, index, mode -> word) SHALL implement the single-bit operation used in RUN.

Verification (N=8, a=10101010 unless stated)
REQ-033 toggle, b=0, len=1 -> done in cycle 2, result 10101011, error 0, busy high only in cycle 1.
REQ-034 set, b=2, len=3 -> done in cycle 4, result 10111110, error 0; clear, b=1, len=4 -> result 10100000.
REQ-035 b=-2, b=9, (b=6, len=3), mode=11 each -> done in cycle 1, error 1, result 10101010.
REQ-036 len=0, toggle, b=3 -> done in cycle 1, result 10101010, error 0.
REQ-037 start pulsed and a changed during RUN of (set, b=0, len=4) -> ignored, result 10101111; back-to-back start in the cycle after done -> accepted.
REQ-038 rst_n low in cycle 2 of (toggle, b=0, len=5) -> outputs zero at once, no done after release, next request completes normally.

Source files
------------

// File: rtl/bit_manip_pkg.sv
// Shared types for the bit manipulation unit: operation modes and FSM states.
package bit_manip_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_SET    = 2'b01,
    MODE_CLEAR  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bit_op_cell.sv
// Single-bit operation: modifies one indexed bit of a word per mode.
module bit_op_cell
  import bit_manip_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  word,
  input  logic [IW-1:0] index,
  input  mode_e         mode,
  output logic [N-1:0]  new_word
);

  always_comb begin
    new_word = word;
    case (mode)
      MODE_TOGGLE: new_word[index] = ~word[index];
      MODE_SET:    new_word[index] = 1'b1;
      MODE_CLEAR:  new_word[index] = 1'b0;
      default:     new_word = word;
    endcase
  end

endmodule

// File: rtl/bit_manip_unit.sv
// Multi-cycle bit-range toggle/set/clear: one bit per RUN cycle, result on DONE.
module bit_manip_unit
  import bit_manip_pkg::*;
#(
  parameter int N  = 8,
  parameter int LW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [LW-1:0] len,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic          error
);

  localparam int IW = $clog2(N);
  // Wide enough that b + len cannot wrap when compared against N.
  localparam int EW = N + LW + 1;

  state_e        state, nxt;
  logic [N-1:0]  word, cell_word;
  logic [IW-1:0] idx;
  logic [LW-1:0] rem;
  mode_e         mode_q;
  logic [EW-1:0] b_ext, len_ext;
  logic          req_err, req_empty, last_bit;

  always_comb begin
    b_ext     = {{(EW-N){1'b0}}, b};
    len_ext   = {{(EW-LW){1'b0}}, len};
    req_err   = b[N-1] | (b_ext >= EW'(N)) | ((b_ext + len_ext) > EW'(N))
              | (mode_e'(mode) == MODE_RSVD);
    req_empty = (len == '0);
    last_bit  = (rem == LW'(1));
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (start) nxt = (req_err || req_empty) ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_bit) nxt = ST_DONE;
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  bit_op_cell #(.N(N), .IW(IW)) u_cell (
    .word     (word),
    .index    (idx),
    .mode     (mode_q),
    .new_word (cell_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word   <= '0;
      idx    <= '0;
      rem    <= '0;
      mode_q <= MODE_TOGGLE;
      result <= '0;
      error  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          if (req_err || req_empty) begin
            // Rejected or empty requests pass the operand straight through.
            result <= a;
            error  <= req_err;
          end else begin
            word   <= a;
            idx    <= b[IW-1:0];
            rem    <= len;
            mode_q <= mode_e'(mode);
          end
        end
        ST_RUN: begin
          word <= cell_word;
          idx  <= idx + IW'(1);
          rem  <= rem - LW'(1);
          if (last_bit) begin
            result <= cell_word;
            error  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule
